// File: rtl/mem_stage_wb_pkg.sv
// Shared CPU definitions: control-bit positions, widths, MEM stage types.
package cpu_defs;
  localparam int DATA_W        = 32;
  localparam int REG_ADDR_W    = 5;

  // WB control field bit positions
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // M control field bit positions
  localparam int M_BRANCH      = 2;
  localparam int M_MEM_READ    = 1;
  localparam int M_MEM_WRITE   = 0;

  typedef enum logic {IDLE, BUSY} mem_state_t;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic [1:0]            wb;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] mux_out;
  } mem_wb_t;
endpackage

// File: rtl/mem_stage_wb_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
module data_mem
  import cpu_defs::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Array is intentionally not reset; contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage_wb.sv
// MEM stage with wait-stated data memory, branch resolution and MEM/WB register.
module mem_stage_wb
  import cpu_defs::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  startin,
  input  logic [1:0]            MEM_wb,
  input  logic                  MEM_branch,
  input  logic                  MEM_mem_read,
  input  logic                  MEM_mem_write,
  input  logic [DATA_W-1:0]     MEM_branch_target,
  input  logic                  MEM_zero,
  input  logic [DATA_W-1:0]     MEM_alu_result,
  input  logic [DATA_W-1:0]     MEM_reg_data2,
  input  logic [REG_ADDR_W-1:0] MEM_mux_out,
  output logic                  MEM_pc_src,
  output logic [DATA_W-1:0]     MEM_pc_target,
  output logic                  mem_stall,
  output logic [1:0]            WB_wb,
  output logic [DATA_W-1:0]     WB_read_data,
  output logic [DATA_W-1:0]     WB_alu_result,
  output logic [REG_ADDR_W-1:0] WB_mux_out
);
  localparam int AW = $clog2(MEM_DEPTH);
  // Counter needs at least one bit even when there are no wait states.
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_C = CW'(WAIT_STATES);

  mem_state_t        state;
  logic [CW-1:0]     cnt;
  mem_wb_t           wb_q;
  logic              access;
  logic              mem_we;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rdata;

  assign access        = MEM_mem_read | MEM_mem_write;
  assign idx           = MEM_alu_result[AW+1:2];
  assign mem_stall     = access & (cnt != WS_C);
  assign MEM_pc_src    = MEM_branch & MEM_zero;
  assign MEM_pc_target = MEM_branch_target;
  // Commit only on the final access edge; a reset on that edge aborts it.
  assign mem_we        = MEM_mem_write & ~mem_stall & ~startin;

  data_mem #(.MEM_DEPTH(MEM_DEPTH)) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .addr (idx),
    .wdata(MEM_reg_data2),
    .rdata(rdata)
  );

  // Wait-state FSM and MEM/WB register; stalled edges push a bubble.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      state <= IDLE;
      cnt   <= '0;
      wb_q  <= '0;
    end else begin
      case (state)
        IDLE: if (mem_stall) begin
          state <= BUSY;
          cnt   <= CW'(1);
        end
        BUSY: if (mem_stall) begin
          cnt   <= cnt + 1'b1;
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (mem_stall) begin
        wb_q <= '0;
      end else begin
        wb_q.wb         <= MEM_wb;
        wb_q.alu_result <= MEM_alu_result;
        wb_q.mux_out    <= MEM_mux_out;
        // Read+write together behaves as a store: no load data.
        wb_q.read_data  <= (MEM_mem_read & ~MEM_mem_write) ? rdata : '0;
      end
    end
  end

  assign WB_wb         = wb_q.wb;
  assign WB_read_data  = wb_q.read_data;
  assign WB_alu_result = wb_q.alu_result;
  assign WB_mux_out    = wb_q.mux_out;
endmodule

// File: tb/tb_mem_stage_wb.sv
// Randomized self-checking bench for mem_stage_wb (WAIT_STATES=2 and 0).
module tb_mem_stage_wb;
  logic clk = 1'b0;
  logic startin;
  always #5 clk = ~clk;

  // DUT with 2 wait states
  logic [1:0]  m_wb;
  logic        m_branch, m_rd, m_wr, m_zero;
  logic [31:0] m_target, m_alu, m_data2;
  logic [4:0]  m_mux;
  logic        pc_src, stall;
  logic [31:0] pc_target, wb_rd, wb_alu;
  logic [1:0]  wb_wb;
  logic [4:0]  wb_mux;

  // DUT with no wait states
  logic [1:0]  z_wb;
  logic        z_rd, z_wr;
  logic [31:0] z_alu, z_data2;
  logic [4:0]  z_mux;
  logic        z_pc_src, z_stall;
  logic [31:0] z_pc_target, z_wb_rd, z_wb_alu;
  logic [1:0]  z_wb_wb;
  logic [4:0]  z_wb_mux;

  int checks = 0;
  int errors = 0;

  // Reference memories: word index is (byte address / 4) modulo depth.
  logic [31:0] model  [256];
  logic [31:0] model0 [256];

  mem_stage_wb #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .startin(startin), .MEM_wb(m_wb), .MEM_branch(m_branch),
    .MEM_mem_read(m_rd), .MEM_mem_write(m_wr), .MEM_branch_target(m_target),
    .MEM_zero(m_zero), .MEM_alu_result(m_alu), .MEM_reg_data2(m_data2),
    .MEM_mux_out(m_mux), .MEM_pc_src(pc_src), .MEM_pc_target(pc_target),
    .mem_stall(stall), .WB_wb(wb_wb), .WB_read_data(wb_rd),
    .WB_alu_result(wb_alu), .WB_mux_out(wb_mux)
  );

  mem_stage_wb #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .startin(startin), .MEM_wb(z_wb), .MEM_branch(1'b0),
    .MEM_mem_read(z_rd), .MEM_mem_write(z_wr), .MEM_branch_target(32'h0),
    .MEM_zero(1'b0), .MEM_alu_result(z_alu), .MEM_reg_data2(z_data2),
    .MEM_mux_out(z_mux), .MEM_pc_src(z_pc_src), .MEM_pc_target(z_pc_target),
    .mem_stall(z_stall), .WB_wb(z_wb_wb), .WB_read_data(z_wb_rd),
    .WB_alu_result(z_wb_alu), .WB_mux_out(z_wb_mux)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  task automatic set_idle();
    m_wb = 2'b00; m_branch = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_zero = 1'b0;
    m_target = '0; m_alu = '0; m_data2 = '0; m_mux = '0;
    z_wb = 2'b00; z_rd = 1'b0; z_wr = 1'b0; z_alu = '0; z_data2 = '0; z_mux = '0;
  endtask

  // Present one instruction to the WAIT_STATES=2 DUT and follow it through.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] wbc,
                           input logic [4:0] mux, input string name);
    int stalls = 0;
    bit done = 0;
    int exp_stalls;
    logic [31:0] exp_rd;
    m_rd = rd; m_wr = wr; m_alu = addr; m_data2 = data; m_wb = wbc; m_mux = mux;
    exp_stalls = (rd | wr) ? 2 : 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        @(posedge clk); #1;
        checks++;
        if (wb_wb !== 2'b00 || wb_rd !== 0 || wb_alu !== 0 || wb_mux !== 0) begin
          errors++;
          $display("FAIL %s bubble: got wb=%b rd=%h alu=%h mux=%h want all 0", name, wb_wb, wb_rd, wb_alu, wb_mux);
        end
      end else done = 1;
    end
    checks++;
    if (!done || stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d (done=%0d) want %0d", name, stalls, done, exp_stalls);
    end
    exp_rd = (rd && !wr) ? model[widx(addr)] : 32'h0;
    @(posedge clk); #1;
    checks++;
    if (wb_wb !== wbc || wb_rd !== exp_rd || wb_alu !== addr || wb_mux !== mux) begin
      errors++;
      $display("FAIL %s wb_regs: got wb=%b rd=%h alu=%h mux=%b want wb=%b rd=%h alu=%h mux=%b",
               name, wb_wb, wb_rd, wb_alu, wb_mux, wbc, exp_rd, addr, mux);
    end
    if (wr) model[widx(addr)] = data;
    set_idle();
  endtask

  task automatic test_reset();
    startin = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wb_wb !== 0 || wb_rd !== 0 || wb_alu !== 0 || wb_mux !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL reset_state: got wb=%b rd=%h alu=%h mux=%h stall=%b want zeros", wb_wb, wb_rd, wb_alu, wb_mux, stall);
    end
    @(negedge clk); startin = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    do_access(1'b0, 1'b1, 32'h20, 32'hCAFEBABE, 2'b00, 5'd0, "store_20");
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'b10101, "load_20");
    checks++;
    if (wb_rd !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL load_cafebabe: got %h want CAFEBABE", wb_rd);
    end
  endtask

  task automatic test_reset_mid();
    do_access(1'b0, 1'b1, 32'h10, 32'h11111111, 2'b00, 5'd0, "prestore_10");
    m_wr = 1'b1; m_alu = 32'h10; m_data2 = 32'hDEADBEEF;
    m_branch = 1'b1; m_zero = 1'b1; m_target = 32'h44;
    @(posedge clk); #1;
    @(negedge clk);
    startin = 1'b1;
    #1;
    checks++;
    if (wb_wb !== 0 || wb_rd !== 0 || wb_alu !== 0 || wb_mux !== 0 || stall !== 1'b1 || pc_src !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got wb=%b rd=%h alu=%h mux=%h stall=%b pc_src=%b want zeros stall=1 pc_src=1",
               wb_wb, wb_rd, wb_alu, wb_mux, stall, pc_src);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_idle();
    startin = 1'b0;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd3, "load_after_reset");
    checks++;
    if (wb_rd !== 32'h11111111) begin
      errors++;
      $display("FAIL reset_no_write: got %h want 11111111", wb_rd);
    end
  endtask

  task automatic test_branch();
    logic [31:0] t;
    m_branch = 1'b1; m_zero = 1'b1; m_target = 32'h30;
    #1;
    checks++;
    if (pc_src !== 1'b1 || pc_target !== 32'h30 || stall !== 1'b0) begin
      errors++;
      $display("FAIL branch_taken: got src=%b tgt=%h stall=%b want 1 00000030 0", pc_src, pc_target, stall);
    end
    m_zero = 1'b0;
    #1;
    checks++;
    if (pc_src !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL branch_not_taken: got src=%b stall=%b want 0 0", pc_src, stall);
    end
    for (int i = 0; i < 6; i++) begin
      t = $urandom;
      m_branch = 1'($urandom_range(0, 1)); m_zero = 1'($urandom_range(0, 1)); m_target = t;
      #1;
      checks++;
      if (pc_src !== (m_branch & m_zero) || pc_target !== t) begin
        errors++;
        $display("FAIL branch_rand: got src=%b tgt=%h want %b %h", pc_src, pc_target, m_branch & m_zero, t);
      end
    end
    set_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    do_access(1'b0, 1'b1, 32'h400, 32'h12345678, 2'b00, 5'd0, "store_400");
    do_access(1'b1, 1'b0, 32'h000, 32'h0, 2'b11, 5'd7, "load_000");
    checks++;
    if (wb_rd !== 32'h12345678) begin
      errors++;
      $display("FAIL wrap: got %h want 12345678", wb_rd);
    end
  endtask

  task automatic test_alu();
    do_access(1'b0, 1'b0, 32'h0F0F0F0F, 32'h0, 2'b10, 5'b11111, "alu_op");
    do_access(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 2'b01, 5'd9, "read_and_write");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int idx;
    for (int i = 32; i < 40; i++)
      do_access(1'b0, 1'b1, 32'(i * 4), $urandom, 2'b00, 5'd0, "seed");
    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(32, 39);
      a = ($urandom & 32'hFFFF_FC03) | 32'(idx << 2);
      case ($urandom_range(0, 3))
        0: do_access(1'b0, 1'b1, a, $urandom, 2'($urandom), 5'($urandom), "rand_store");
        1: do_access(1'b1, 1'b0, a, $urandom, 2'($urandom), 5'($urandom), "rand_load");
        2: do_access(1'b0, 1'b0, $urandom, $urandom, 2'($urandom), 5'($urandom), "rand_alu");
        default: do_access(1'b1, 1'b1, a, $urandom, 2'($urandom), 5'($urandom), "rand_both");
      endcase
    end
  endtask

  // Alternating store/load, one per cycle, on the zero-wait-state DUT.
  task automatic test_back_to_back();
    logic [31:0] a, d, exp;
    bit is_load;
    for (int n = 0; n < 24; n++) begin
      is_load = n[0];
      if (!is_load) begin
        a = ($urandom & 32'hFFFF_FC03) | 32'($urandom_range(0, 15) << 2);
        d = $urandom;
      end
      z_rd = is_load; z_wr = !is_load; z_alu = a; z_data2 = d;
      z_wb = 2'($urandom); z_mux = 5'($urandom);
      exp = is_load ? model0[widx(a)] : 32'h0;
      @(negedge clk);
      checks++;
      if (z_stall !== 1'b0) begin
        errors++;
        $display("FAIL ws0_stall: got %b want 0 at op %0d", z_stall, n);
      end
      @(posedge clk); #1;
      checks++;
      if (z_wb_rd !== exp || z_wb_alu !== a || z_wb_wb !== z_wb || z_wb_mux !== z_mux) begin
        errors++;
        $display("FAIL ws0_data op %0d: got rd=%h alu=%h wb=%b mux=%b want rd=%h alu=%h wb=%b mux=%b",
                 n, z_wb_rd, z_wb_alu, z_wb_wb, z_wb_mux, exp, a, z_wb, z_mux);
      end
      if (!is_load) model0[widx(a)] = d;
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_reset_mid();
    test_branch();
    test_wrap();
    test_alu();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
